fold3_scheduler: RTL and testbench

Sequencer for the 3-folded IIR datapath. Accepts 20-bit input samples through a valid/ready handshake, buffers one sample, and drives the folded datapath through its three time-multiplexed phases per sample. Tracks each issued sample through the datapath's fixed pipeline latency and registers the filter output with a one-cycle valid strobe. Sits between the sample source and the shared multiplier/adder/delay datapath.

---
 rtl/fold_pkg.sv | 21 ++
 rtl/fold_tag_pipe.sv | 40 ++++
 rtl/fold3_scheduler.sv | 122 ++++++++++++
 tb/tb_fold3_scheduler.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fold_pkg.sv
// fold_pkg: shared definitions for the 3-folded IIR sequencer.
//   W       - default sample/result width
//   phase_t - 2-bit fold phase selector, PH0..PH2
//   state_t - sequencer states IDLE, P0, P1, P2
package fold_pkg;

  localparam int W = 20;

  typedef logic [1:0] phase_t;
  localparam phase_t PH0 = 2'd0;
  localparam phase_t PH1 = 2'd1;
  localparam phase_t PH2 = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    P0   = 2'd1,
    P1   = 2'd2,
    P2   = 2'd3
  } state_t;

endpackage

// File: rtl/fold_tag_pipe.sv
// fold_tag_pipe: LAT-deep 1-bit shift register that follows each issued
// sample through the fixed datapath latency.
//   clk, rst_n - clock, asynchronous active-low reset
//   tag_i      - new tag entering stage 0 (high on a phase-2 cycle)
//   tag_o      - last stage; high in the cycle dp_y is valid
//   any_o      - OR of all stages, i.e. a result is still in flight
module fold_tag_pipe #(
  parameter int LAT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tag_i,
  output logic tag_o,
  output logic any_o
);

  logic [LAT-1:0] tag_q;
  logic [LAT-1:0] tag_d;

  // LAT == 1 needs its own branch: the general shift would slice [-1:0].
  generate
    if (LAT == 1) begin : g_single
      assign tag_d = tag_i;
    end else begin : g_shift
      assign tag_d = {tag_q[LAT-2:0], tag_i};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign tag_o = tag_q[LAT-1];
  assign any_o = |tag_q;

endmodule

// File: rtl/fold3_scheduler.sv
// fold3_scheduler: sequencer for the 3-folded IIR datapath.
// Buffers one input sample, walks the shared datapath through phases 0..2
// per sample, and registers dp_y LAT cycles after each phase-2 cycle.
//   clk, rst_n         - clock, asynchronous active-low reset
//   en                 - run enable (does not abort an iteration in progress)
//   in_valid/in_data   - sample offer; in_ready = holding buffer empty
//   dp_x/dp_phase/dp_en- datapath controls; dp_y - datapath result
//   y_data/y_valid     - registered result and its one-cycle strobe
//   busy               - sequencing or a result still in flight
//   sample_cnt         - results emitted, wrapping
module fold3_scheduler #(
  parameter int W     = fold_pkg::W,
  parameter int LAT   = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  output logic [W-1:0]     dp_x,
  output logic [1:0]       dp_phase,
  output logic             dp_en,
  input  logic [W-1:0]     dp_y,
  output logic [W-1:0]     y_data,
  output logic             y_valid,
  output logic             busy,
  output logic [CNT_W-1:0] sample_cnt
);

  fold_pkg::state_t state_q, state_d;
  logic             buf_full_q;
  logic [W-1:0]     buf_q;
  logic [W-1:0]     dp_x_q;
  logic [W-1:0]     y_data_q;
  logic             y_valid_q;
  logic [CNT_W-1:0] cnt_q;

  logic accept;
  logic consume;
  logic tag_last;
  logic tag_any;

  // in_ready is low whenever the buffer is full, so accept and consume
  // can never fall on the same edge.
  assign accept  = in_valid & ~buf_full_q;
  assign consume = (state_d == fold_pkg::P0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      fold_pkg::IDLE: if (buf_full_q && en) state_d = fold_pkg::P0;
      fold_pkg::P0:   state_d = fold_pkg::P1;
      fold_pkg::P1:   state_d = fold_pkg::P2;
      fold_pkg::P2:   state_d = (buf_full_q && en) ? fold_pkg::P0 : fold_pkg::IDLE;
      default:        state_d = fold_pkg::IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= fold_pkg::IDLE;
      buf_full_q <= 1'b0;
      buf_q      <= '0;
      dp_x_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        buf_q      <= in_data;
        buf_full_q <= 1'b1;
      end else if (consume) begin
        buf_full_q <= 1'b0;
      end
      if (consume) begin
        dp_x_q <= buf_q;
      end
    end
  end

  fold_tag_pipe #(
    .LAT (LAT)
  ) u_tag_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .tag_i (state_q == fold_pkg::P2),
    .tag_o (tag_last),
    .any_o (tag_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_data_q  <= '0;
      y_valid_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      y_valid_q <= tag_last;
      if (tag_last) begin
        y_data_q <= dp_y;
        cnt_q    <= cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    dp_phase = fold_pkg::PH0;
    unique case (state_q)
      fold_pkg::P1: dp_phase = fold_pkg::PH1;
      fold_pkg::P2: dp_phase = fold_pkg::PH2;
      default:      dp_phase = fold_pkg::PH0;
    endcase
  end

  assign in_ready   = ~buf_full_q;
  assign dp_en      = (state_q != fold_pkg::IDLE);
  assign dp_x       = dp_x_q;
  assign y_data     = y_data_q;
  assign y_valid    = y_valid_q;
  assign busy       = (state_q != fold_pkg::IDLE) | tag_any;
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_fold3_scheduler.sv
// Testbench for fold3_scheduler. Stimulus pushes expected results
// (cycle, value, count) into a queue; a monitor pops and compares them
// whenever y_valid is seen. A second instance with CNT_W = 2 covers wrap.
module tb_fold3_scheduler;

  localparam int W   = 20;
  localparam int LAT = 3;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic [W-1:0] dp_y;

  logic         in_ready, dp_en, y_valid, busy;
  logic [W-1:0] dp_x, y_data;
  logic [1:0]   dp_phase;
  logic [15:0]  sample_cnt;

  logic         in_ready2, dp_en2, y_valid2, busy2;
  logic [W-1:0] dp_x2, y_data2;
  logic [1:0]   dp_phase2;
  logic [1:0]   sample_cnt2;

  fold3_scheduler #(.W(W), .LAT(LAT), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .dp_x(dp_x), .dp_phase(dp_phase), .dp_en(dp_en),
    .dp_y(dp_y), .y_data(y_data), .y_valid(y_valid), .busy(busy),
    .sample_cnt(sample_cnt)
  );

  fold3_scheduler #(.W(W), .LAT(LAT), .CNT_W(2)) u_dut_w2 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready2), .dp_x(dp_x2), .dp_phase(dp_phase2), .dp_en(dp_en2),
    .dp_y(dp_y), .y_data(y_data2), .y_valid(y_valid2), .busy(busy2),
    .sample_cnt(sample_cnt2)
  );

  typedef struct {
    int           cyc;
    logic [W-1:0] data;
    int           cnt;
  } exp_t;

  exp_t         sbq[$];
  int           push_cnt = 0;
  int           checks   = 0;
  int           failures = 0;
  int           cyc      = 0;
  int           special_cyc = -1;
  logic [W-1:0] special_val = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Datapath stand-in: a distinct, cycle-dependent value every cycle.
  function automatic logic [W-1:0] dpy_of(input int c);
    if (c == special_cyc) return special_val;
    return W'((c * 32'h0003_1337) ^ 32'h0005_A5A5);
  endfunction

  initial begin
    dp_y = '0;
    forever begin
      @(negedge clk);
      dp_y = dpy_of(cyc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // y_valid is expected in ycyc; dp_y is sampled one cycle earlier.
  task automatic push_result(input int ycyc);
    exp_t e;
    push_cnt++;
    e.cyc  = ycyc;
    e.data = dpy_of(ycyc - 1);
    e.cnt  = push_cnt;
    sbq.push_back(e);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: pops one expected result per y_valid strobe.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
          e = sbq.pop_front();
          chk("missed_y_valid", 32'(cyc), 32'(e.cyc));
        end
        if (y_valid === 1'b1) begin
          if (sbq.size() == 0) begin
            chk("unexpected_y_valid", 32'(y_valid), 32'd0);
          end else begin
            e = sbq.pop_front();
            $display("y_valid cycle=%0d y_data=%05h sample_cnt=%0d cnt2=%0d",
                     cyc, y_data, sample_cnt, sample_cnt2);
            chk("y_cycle", 32'(cyc), 32'(e.cyc));
            chk("y_data", 32'(y_data), 32'(e.data));
            chk("sample_cnt", 32'(sample_cnt), 32'(e.cnt));
            chk("y_valid_w2", 32'(y_valid2), 32'd1);
            chk("y_data_w2", 32'(y_data2), 32'(e.data));
            chk("sample_cnt_w2", 32'(sample_cnt2), 32'(e.cnt % 4));
          end
        end else if (y_valid2 === 1'b1) begin
          chk("unexpected_y_valid_w2", 32'(y_valid2), 32'd0);
        end
      end
    end
  end

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_y_valid"}, 32'(y_valid), 32'd0);
    chk({tag, "_dp_en"}, 32'(dp_en), 32'd0);
    chk({tag, "_dp_phase"}, 32'(dp_phase), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_sample_cnt"}, 32'(sample_cnt), 32'd0);
  endtask

  // Holds in_valid high until n samples are taken. From IDLE, accepts land
  // at offsets 0, 2, 5, 8, ... and P0 at offsets 2, 5, 8, ...
  task automatic stream(input int n);
    int a;
    int nacc;
    logic [W-1:0] smp [8];
    logic rdy;
    a = cyc;
    nacc = 0;
    for (int i = 0; i < n; i++) begin
      smp[i] = W'((i + 1) * 32'h11111);
      push_result(a + LAT + 5 + 3 * i);
    end
    en = 1'b1;
    for (int k = 0; k <= 3 * n + 1; k++) begin
      rdy = in_ready;
      if (k <= 8)
        chk("stream_in_ready", 32'(rdy), 32'((k == 0 || k == 2 || k == 5 || k == 8) ? 1 : 0));
      for (int i = 0; i < n; i++) begin
        if (k == 3 * i + 2) begin
          chk("stream_p0_phase", 32'(dp_phase), 32'd0);
          chk("stream_p0_dp_x", 32'(dp_x), 32'(smp[i]));
        end
      end
      in_valid = (nacc < n);
      in_data  = (nacc < n) ? smp[nacc] : '0;
      if (in_valid && rdy) begin
        chk("stream_accept_cycle", 32'(k), 32'((nacc == 0) ? 0 : 3 * nacc - 1));
        nacc++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("stream_accepts", 32'(nacc), 32'(n));
    wait_to(a + LAT + 5 + 3 * n + 2);
  endtask

  initial begin
    int a;
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int a;
    rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; in_data = '0;

    // Reset state, during and after reset.
    repeat (3) @(negedge clk);
    chk_idle("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle("post_rst");

    // Single sample from IDLE.
    a = cyc;
    special_cyc = a + LAT + 4;
    special_val = 20'hABCDE;
    push_result(a + LAT + 5);
    en = 1'b1; in_valid = 1'b1; in_data = 20'h00123;
    @(negedge clk);
    in_valid = 1'b0;
    chk("single_in_ready_full", 32'(in_ready), 32'd0);
    chk("single_dp_en_idle", 32'(dp_en), 32'd0);
    for (int p = 0; p < 3; p++) begin
      @(negedge clk);
      chk("single_phase", 32'(dp_phase), 32'(p));
      chk("single_dp_en", 32'(dp_en), 32'd1);
      chk("single_dp_x", 32'(dp_x), 32'h00123);
    end
    @(negedge clk);
    chk("single_dp_en_after", 32'(dp_en), 32'd0);
    chk("single_busy_inflight", 32'(busy), 32'd1);
    chk("single_dp_x_hold", 32'(dp_x), 32'h00123);
    wait_to(a + 10);
    chk("single_cnt", 32'(sample_cnt), 32'd1);
    chk("single_busy_done", 32'(busy), 32'd0);

    // Streaming, 4 samples.
    stream(4);
    chk("stream_cnt", 32'(sample_cnt), 32'd5);
    chk("stream_busy", 32'(busy), 32'd0);

    // Enable drop during P1 with a second sample buffered.
    a = cyc;
    push_result(a + 8);
    push_result(a + 14);
    en = 1'b1; in_valid = 1'b1; in_data = 20'h0F0F0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("endrop_ready_p0", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = 20'h5A5A5;
    @(negedge clk);
    in_valid = 1'b0;
    chk("endrop_p1", 32'(dp_phase), 32'd1);
    en = 1'b0;
    @(negedge clk);
    chk("endrop_p2", 32'(dp_phase), 32'd2);
    for (int k = 5; k <= 6; k++) begin
      @(negedge clk);
      chk("endrop_idle_dp_en", 32'(dp_en), 32'd0);
      chk("endrop_idle_ready", 32'(in_ready), 32'd0);
      chk("endrop_idle_dp_x", 32'(dp_x), 32'h0F0F0);
    end
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    chk("endrop_resume_phase", 32'(dp_phase), 32'd0);
    chk("endrop_resume_dp_en", 32'(dp_en), 32'd1);
    chk("endrop_resume_dp_x", 32'(dp_x), 32'h5A5A5);
    wait_to(a + 16);
    chk("endrop_cnt", 32'(sample_cnt), 32'd7);

    // Reset pulse during P1 of the second sample, a third one buffered.
    a = cyc;
    in_valid = 1'b1; in_data = 20'h13579;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data = 20'h2468A;
    @(negedge clk);
    in_valid = 1'b0;
    wait_to(a + 5);
    in_valid = 1'b1; in_data = 20'h77777;
    @(negedge clk);
    in_valid = 1'b0;
    chk("midrst_p1", 32'(dp_phase), 32'd1);
    chk("midrst_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    sbq.delete();
    push_cnt = 0;
    #1;
    chk_idle("midrst_during");
    @(negedge clk);
    rst_n = 1'b1;
    wait_to(a + 16);
    chk_idle("midrst_after");
    chk("midrst_dp_x", 32'(dp_x), 32'd0);

    // Counter wrap on the CNT_W = 2 instance: 1, 2, 3, 0, 1.
    stream(5);
    chk("wrap_cnt2", 32'(sample_cnt2), 32'd1);
    chk("wrap_cnt", 32'(sample_cnt), 32'd5);

    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
